fft_out_reorder: RTL and testbench

- Downstream of the 4-lane N=128 FFT pipeline. Consumes its four complex outputs per cycle, which arrive in bit-reversed bin order.
- Uses a ping-pong, 4-bank buffer to reorder them into natural bin order.
- Emits 4 consecutive bins per cycle with a valid/ready handshake to the consumer (magnitude/detector stage).
- Flags frame-alignment errors and overflow caused by sustained consumer stall.

---
 rtl/fft_pkg.sv | 34 +++
 rtl/fft_reorder_bank.sv | 31 +++
 rtl/fft_out_reorder.sv | 236 +++++++++++++++++++++++
 tb/tb_fft_out_reorder.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Constants and index helpers shared by the FFT output reorder buffer.
// The helpers cover the bit-reversal of pipeline output slots and the bin-to-bank mapping of the reorder RAM.
package fft_pkg;

    localparam int FFT_N         = 128;
    localparam int FFT_LOG2N     = $clog2(FFT_N);
    localparam int FFT_NBITS_OUT = 19;

    localparam int NUM_LANES = 4;

    // Position of each FFT output port within a 4-slot input beat (slot s = 4c + lane)
    localparam int LANE_IN0_UP   = 0;
    localparam int LANE_IN0_DOWN = 1;
    localparam int LANE_IN1_UP   = 2;
    localparam int LANE_IN1_DOWN = 3;

    localparam logic [1:0] WR_IDLE  = 2'd0;
    localparam logic [1:0] WR_WRITE = 2'd1;
    localparam logic [1:0] WR_DROP  = 2'd2;

    // Reverse the low w bits of v; the result is zero above bit w-1
    function automatic logic [15:0] bitrev(input logic [15:0] v, input int w);
        logic [15:0] r;
        r = {<<{v}};
        return r >> (16 - w);
    endfunction

    // Bank holding bin b: XOR of its two LSBs and its two MSBs keeps both the
    // bit-reversed write beat and the natural-order read beat conflict-free
    function automatic logic [1:0] bank_of(input logic [15:0] b, input int w);
        return b[1:0] ^ 2'(b >> (w - 2));
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// Simple dual-port RAM bank used by the reorder buffer.
// One write port, one read port with a registered, enable-gated output that holds its value when not read.
module fft_reorder_bank #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 38,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_out_reorder.sv
// Reorders the 4-lane bit-reversed FFT output into natural bin order using a
// ping-pong 4-bank buffer, emitting 4 consecutive bins per beat over valid/ready.
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int NBITS_out = FFT_NBITS_OUT,
    parameter int N         = FFT_N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*NBITS_out-1:0] fftIn0_up,
    input  logic [2*NBITS_out-1:0] fftIn0_down,
    input  logic [2*NBITS_out-1:0] fftIn1_up,
    input  logic [2*NBITS_out-1:0] fftIn1_down,
    input  logic                   in_valid,
    input  logic                   in_sof,
    output logic [2*NBITS_out-1:0] binOut0,
    output logic [2*NBITS_out-1:0] binOut1,
    output logic [2*NBITS_out-1:0] binOut2,
    output logic [2*NBITS_out-1:0] binOut3,
    output logic                   out_valid,
    output logic                   out_sof,
    output logic                   out_eof,
    input  logic                   out_ready,
    output logic                   overflow,
    output logic                   frame_err
);

    localparam int LOG2N = $clog2(N);
    localparam int W     = 2 * NBITS_out;
    localparam int CW    = LOG2N - 2;
    localparam int AW    = CW + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(N / 4 - 1);

    logic [1:0]    wr_state_q, wr_state_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic          wr_half_q, wr_half_d;
    logic [1:0]    full_q, full_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic          rd_half_q, rd_half_d;
    logic          out_valid_q, out_valid_d;
    logic          out_sof_q, out_sof_d;
    logic          out_eof_q, out_eof_d;
    logic [CW-1:0] out_k_q, out_k_d;
    logic          out_half_q, out_half_d;
    logic          overflow_q, overflow_d;
    logic          frame_err_q, frame_err_d;

    logic          wr_en;
    logic [CW-1:0] wr_beat;
    logic [1:0]    set_full;
    logic [1:0]    release_full;
    logic          half_avail;
    logic          advance;
    logic          rd_issue;
    logic [AW-1:0] rd_addr;

    logic [W-1:0]  lane_in   [NUM_LANES];
    logic [1:0]    lane_bank [NUM_LANES];
    logic [CW-1:0] lane_addr [NUM_LANES];
    logic [AW-1:0] wr_addr   [NUM_LANES];
    logic [W-1:0]  wr_data   [NUM_LANES];
    logic [W-1:0]  rd_data   [NUM_LANES];
    logic [1:0]    bin_sel   [NUM_LANES];
    logic [W-1:0]  bin_out   [NUM_LANES];

    assign lane_in[LANE_IN0_UP]   = fftIn0_up;
    assign lane_in[LANE_IN0_DOWN] = fftIn0_down;
    assign lane_in[LANE_IN1_UP]   = fftIn1_up;
    assign lane_in[LANE_IN1_DOWN] = fftIn1_down;

    // A half released by the final accepted beat this cycle may be refilled in the same cycle
    assign release_full = (out_valid_q && out_ready && out_eof_q) ? 2'(2'b01 << out_half_q) : 2'b00;
    assign half_avail   = !full_q[wr_half_q] || release_full[wr_half_q];

    always_comb begin
        wr_state_d  = wr_state_q;
        wr_cnt_d    = wr_cnt_q;
        wr_half_d   = wr_half_q;
        wr_en       = 1'b0;
        wr_beat     = wr_cnt_q;
        set_full    = 2'b00;
        overflow_d  = overflow_q;
        frame_err_d = frame_err_q;
        if (in_valid) begin
            case (wr_state_q)
                WR_WRITE: begin
                    wr_en = 1'b1;
                    if (in_sof) begin
                        frame_err_d = 1'b1;
                        wr_beat     = '0;
                        wr_cnt_d    = CW'(1);
                    end else if (wr_cnt_q == LAST_BEAT) begin
                        set_full[wr_half_q] = 1'b1;
                        wr_half_d  = ~wr_half_q;
                        wr_cnt_d   = '0;
                        wr_state_d = WR_IDLE;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
                WR_DROP: begin
                    if (in_sof && half_avail) begin
                        wr_en      = 1'b1;
                        wr_beat    = '0;
                        wr_cnt_d   = CW'(1);
                        wr_state_d = WR_WRITE;
                    end
                end
                default: begin
                    if (!in_sof) begin
                        frame_err_d = 1'b1;
                    end else if (half_avail) begin
                        wr_en      = 1'b1;
                        wr_beat    = '0;
                        wr_cnt_d   = CW'(1);
                        wr_state_d = WR_WRITE;
                    end else begin
                        overflow_d = 1'b1;
                        wr_state_d = WR_DROP;
                    end
                end
            endcase
        end
    end

    assign full_d = (full_q & ~release_full) | set_full;

    // The output stage is a single slot; a read is issued only when that slot can take it
    assign advance  = !out_valid_q || out_ready;
    assign rd_issue = advance && full_q[rd_half_q];
    assign rd_addr  = {rd_half_q, rd_cnt_q};

    always_comb begin
        rd_cnt_d    = rd_cnt_q;
        rd_half_d   = rd_half_q;
        out_valid_d = out_valid_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        out_k_d     = out_k_q;
        out_half_d  = out_half_q;
        if (rd_issue) begin
            out_valid_d = 1'b1;
            out_sof_d   = (rd_cnt_q == '0);
            out_eof_d   = (rd_cnt_q == LAST_BEAT);
            out_k_d     = rd_cnt_q;
            out_half_d  = rd_half_q;
            rd_cnt_d    = rd_cnt_q + 1'b1;
            if (rd_cnt_q == LAST_BEAT) begin
                rd_half_d = ~rd_half_q;
            end
        end else if (advance) begin
            out_valid_d = 1'b0;
            out_sof_d   = 1'b0;
            out_eof_d   = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lane_bank[gi] = bank_of(bitrev(16'({wr_beat, 2'(gi)}), LOG2N), LOG2N);
            assign lane_addr[gi] = CW'(bitrev(16'({wr_beat, 2'(gi)}), LOG2N) >> 2);

            // Write crossbar: pick the one lane whose bin maps onto this bank
            always_comb begin
                wr_data[gi] = '0;
                wr_addr[gi] = '0;
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (lane_bank[l] == 2'(gi)) begin
                        wr_data[gi] = lane_in[l];
                        wr_addr[gi] = {wr_half_q, lane_addr[l]};
                    end
                end
            end

            fft_reorder_bank #(
                .DEPTH (2 * N / 4),
                .WIDTH (W)
            ) u_bank (
                .clk_i     (clk),
                .wr_en_i   (wr_en),
                .wr_addr_i (wr_addr[gi]),
                .wr_data_i (wr_data[gi]),
                .rd_en_i   (rd_issue),
                .rd_addr_i (rd_addr),
                .rd_data_o (rd_data[gi])
            );

            assign bin_sel[gi] = bank_of(16'({out_k_q, 2'(gi)}), LOG2N);
            assign bin_out[gi] = out_valid_q ? rd_data[bin_sel[gi]] : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state_q  <= WR_IDLE;
            wr_cnt_q    <= '0;
            wr_half_q   <= 1'b0;
            full_q      <= 2'b00;
            rd_cnt_q    <= '0;
            rd_half_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_k_q     <= '0;
            out_half_q  <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_half_q   <= wr_half_d;
            full_q      <= full_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_half_q   <= rd_half_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            out_k_q     <= out_k_d;
            out_half_q  <= out_half_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign binOut0   = bin_out[0];
    assign binOut1   = bin_out[1];
    assign binOut2   = bin_out[2];
    assign binOut3   = bin_out[3];
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed testbench for fft_out_reorder: bit-reversed input frames tagged per frame,
// outputs collected on the falling edge and compared against natural bin order.
module tb_fft_out_reorder;

    localparam int NB    = 19;
    localparam int W     = 2 * NB;
    localparam int NBEAT = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] fftIn0_up = '0, fftIn0_down = '0, fftIn1_up = '0, fftIn1_down = '0;
    logic         in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
    logic [W-1:0] binOut0, binOut1, binOut2, binOut3;
    logic         out_valid, out_sof, out_eof, overflow, frame_err;

    fft_out_reorder dut (
        .clk         (clk),
        .rst         (rst),
        .fftIn0_up   (fftIn0_up),
        .fftIn0_down (fftIn0_down),
        .fftIn1_up   (fftIn1_up),
        .fftIn1_down (fftIn1_down),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .binOut0     (binOut0),
        .binOut1     (binOut1),
        .binOut2     (binOut2),
        .binOut3     (binOut3),
        .out_valid   (out_valid),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .out_ready   (out_ready),
        .overflow    (overflow),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [4*W-1:0] data;
        logic           sof;
        logic           eof;
        int             cyc;
    } beat_t;

    beat_t          beats[$];
    beat_t          bt;
    logic [4*W-1:0] cur_data, prev_data;
    bit             prev_stall = 0;
    int             stall_seen = 0;
    int             stall_viol = 0;

    // Records every beat that will be accepted at the next rising edge and
    // checks that a stalled beat is still presented unchanged one cycle later
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 0;
        end else begin
            cur_data = {binOut0, binOut1, binOut2, binOut3};
            if (prev_stall) begin
                stall_seen++;
                if (!out_valid || cur_data !== prev_data) stall_viol++;
            end
            if (out_valid && out_ready) begin
                bt.data = cur_data;
                bt.sof  = out_sof;
                bt.eof  = out_eof;
                bt.cyc  = cyc;
                beats.push_back(bt);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = cur_data;
        end
    end

    function automatic int bitrev7(int s);
        int r = 0;
        for (int i = 0; i < 7; i++) r |= ((s >> i) & 1) << (6 - i);
        return r;
    endfunction

    // Value carried by bin b of frame f: re = b + 256f, im = -(b + 256f)
    function automatic logic [W-1:0] mk(int b, int f);
        int v = b + 256 * f;
        logic [NB-1:0] re = NB'(v);
        logic [NB-1:0] im = NB'(-v);
        return {re, im};
    endfunction

    function automatic logic [4*W-1:0] exp_beat(int k, int f);
        return {mk(4*k, f), mk(4*k+1, f), mk(4*k+2, f), mk(4*k+3, f)};
    endfunction

    task automatic drive_beat(int f, int c, bit sof);
        @(posedge clk); #1;
        fftIn0_up   = mk(bitrev7(4*c + 0), f);
        fftIn0_down = mk(bitrev7(4*c + 1), f);
        fftIn1_up   = mk(bitrev7(4*c + 2), f);
        fftIn1_down = mk(bitrev7(4*c + 3), f);
        in_valid    = 1'b1;
        in_sof      = sof;
    endtask

    task automatic send_frame(int f, int nbeats, output int last_cyc);
        for (int c = 0; c < nbeats; c++) drive_beat(f, c, c == 0);
        last_cyc = cyc;
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wait_beats(int n, int budget, output bit ok);
        for (int i = 0; i < budget && beats.size() < n; i++) @(posedge clk);
        ok = (beats.size() >= n);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        beats.delete();
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #2;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if ({out_sof, out_eof} !== 2'b00) begin fails++; $display("FAIL reset_sof_eof got %b want 00", {out_sof, out_eof}); end
        tests++; if ({overflow, frame_err} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {overflow, frame_err}); end
        tests++; if ({binOut0, binOut1, binOut2, binOut3} !== '0) begin fails++; $display("FAIL reset_bins got %h want 0", {binOut0, binOut1, binOut2, binOut3}); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        $display("[TB] reset: outputs checked");
    endtask

    task automatic test_single_frame();
        int  t_last;
        bit  ok;
        beats.delete();
        send_frame(1, NBEAT, t_last);
        go_idle();
        wait_beats(NBEAT, 100, ok);
        tests++; if (!ok) begin fails++; $display("FAIL single_timeout got %0d beats want %0d", beats.size(), NBEAT); end
        repeat (5) @(posedge clk);
        tests++; if (beats.size() != NBEAT) begin fails++; $display("FAIL single_count got %0d want %0d", beats.size(), NBEAT); end
        if (beats.size() == NBEAT) begin
            tests++; if (beats[0].cyc != t_last + 2) begin fails++; $display("FAIL single_latency got cycle %0d want %0d", beats[0].cyc, t_last + 2); end
            tests++; if (beats[31].cyc != beats[0].cyc + 31) begin fails++; $display("FAIL single_eof_time got cycle %0d want %0d", beats[31].cyc, beats[0].cyc + 31); end
            for (int k = 0; k < NBEAT; k++) begin
                tests++;
                if (beats[k].data !== exp_beat(k, 1) || beats[k].sof !== (k == 0) || beats[k].eof !== (k == 31)) begin
                    fails++;
                    $display("FAIL single_beat%0d got %h sof%b eof%b want %h sof%b eof%b", k, beats[k].data, beats[k].sof, beats[k].eof, exp_beat(k, 1), k == 0, k == 31);
                end
            end
        end
        tests++; if ({overflow, frame_err} !== 2'b00) begin fails++; $display("FAIL single_flags got %b want 00", {overflow, frame_err}); end
        $display("[TB] single frame: %0d beats received", beats.size());
    endtask

    task automatic test_back_to_back();
        int t_a, t_b, t_c;
        bit ok;
        int gaps = 0;
        beats.delete();
        send_frame(2, NBEAT, t_a);
        send_frame(3, NBEAT, t_b);
        send_frame(4, NBEAT, t_c);
        go_idle();
        wait_beats(3 * NBEAT, 200, ok);
        tests++; if (!ok) begin fails++; $display("FAIL b2b_timeout got %0d beats want %0d", beats.size(), 3 * NBEAT); end
        repeat (5) @(posedge clk);
        tests++; if (beats.size() != 3 * NBEAT) begin fails++; $display("FAIL b2b_count got %0d want %0d", beats.size(), 3 * NBEAT); end
        if (beats.size() == 3 * NBEAT) begin
            tests++; if (beats[0].cyc != t_a + 2) begin fails++; $display("FAIL b2b_latency got cycle %0d want %0d", beats[0].cyc, t_a + 2); end
            for (int i = 0; i < 3 * NBEAT; i++) begin
                if (beats[i].cyc != beats[0].cyc + i) gaps++;
                tests++;
                if (beats[i].data !== exp_beat(i % NBEAT, 2 + i / NBEAT) || beats[i].sof !== (i % NBEAT == 0) || beats[i].eof !== (i % NBEAT == 31)) begin
                    fails++;
                    $display("FAIL b2b_beat%0d got %h sof%b eof%b want %h", i, beats[i].data, beats[i].sof, beats[i].eof, exp_beat(i % NBEAT, 2 + i / NBEAT));
                end
            end
            tests++; if (gaps != 0) begin fails++; $display("FAIL b2b_continuity got %0d bubbles want 0", gaps); end
        end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL b2b_overflow got %b want 0", overflow); end
        $display("[TB] back-to-back: %0d beats received for frames 2,3,4", beats.size());
    endtask

    task automatic test_stall_toggle();
        int t_last;
        bit ok;
        beats.delete();
        stall_seen = 0;
        stall_viol = 0;
        fork
            begin
                send_frame(5, NBEAT, t_last);
                go_idle();
            end
            begin
                repeat (90) begin
                    @(posedge clk); #1;
                    out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        wait_beats(NBEAT, 100, ok);
        tests++; if (!ok) begin fails++; $display("FAIL stall_timeout got %0d beats want %0d", beats.size(), NBEAT); end
        repeat (5) @(posedge clk);
        tests++; if (beats.size() != NBEAT) begin fails++; $display("FAIL stall_count got %0d want %0d", beats.size(), NBEAT); end
        if (beats.size() == NBEAT) begin
            for (int k = 0; k < NBEAT; k++) begin
                tests++;
                if (beats[k].data !== exp_beat(k, 5) || beats[k].sof !== (k == 0) || beats[k].eof !== (k == 31)) begin
                    fails++;
                    $display("FAIL stall_beat%0d got %h want %h", k, beats[k].data, exp_beat(k, 5));
                end
            end
        end
        tests++; if (stall_seen == 0) begin fails++; $display("FAIL stall_seen got 0 stalled cycles want >0"); end
        tests++; if (stall_viol != 0) begin fails++; $display("FAIL stall_hold got %0d unstable cycles want 0", stall_viol); end
        $display("[TB] stall toggle: %0d beats, %0d stall cycles", beats.size(), stall_seen);
    endtask

    task automatic test_overflow();
        int t_last;
        bit ok;
        do_reset();
        out_ready = 1'b0;
        send_frame(6, NBEAT, t_last);
        send_frame(7, NBEAT, t_last);
        #2;
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_early got %b want 0", overflow); end
        send_frame(8, NBEAT, t_last);
        go_idle();
        repeat (5) @(posedge clk);
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", overflow); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL ovf_frame_err got %b want 0", frame_err); end
        tests++; if (beats.size() != 0 || out_valid !== 1'b1 || out_sof !== 1'b1) begin fails++; $display("FAIL ovf_hold got beats=%0d valid=%b sof=%b want 0 1 1", beats.size(), out_valid, out_sof); end
        #1 out_ready = 1'b1;
        wait_beats(2 * NBEAT, 150, ok);
        tests++; if (!ok) begin fails++; $display("FAIL ovf_timeout got %0d beats want %0d", beats.size(), 2 * NBEAT); end
        repeat (10) @(posedge clk);
        tests++; if (beats.size() != 2 * NBEAT) begin fails++; $display("FAIL ovf_count got %0d want %0d", beats.size(), 2 * NBEAT); end
        if (beats.size() == 2 * NBEAT) begin
            for (int i = 0; i < 2 * NBEAT; i++) begin
                tests++;
                if (beats[i].data !== exp_beat(i % NBEAT, 6 + i / NBEAT) || beats[i].sof !== (i % NBEAT == 0)) begin
                    fails++;
                    $display("FAIL ovf_beat%0d got %h want %h", i, beats[i].data, exp_beat(i % NBEAT, 6 + i / NBEAT));
                end
            end
        end
        $display("[TB] overflow: %0d beats received for frames 6,7; frame 8 dropped", beats.size());
    endtask

    task automatic test_frame_err();
        int t_last;
        bit ok;
        do_reset();
        tests++; if ({overflow, frame_err} !== 2'b00) begin fails++; $display("FAIL ferr_cleared got %b want 00", {overflow, frame_err}); end
        send_frame(9, 10, t_last);
        send_frame(10, NBEAT, t_last);
        go_idle();
        wait_beats(NBEAT, 100, ok);
        tests++; if (!ok) begin fails++; $display("FAIL ferr_timeout got %0d beats want %0d", beats.size(), NBEAT); end
        repeat (5) @(posedge clk);
        tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL ferr_flag got %b want 1", frame_err); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ferr_overflow got %b want 0", overflow); end
        tests++; if (beats.size() != NBEAT) begin fails++; $display("FAIL ferr_count got %0d want %0d", beats.size(), NBEAT); end
        if (beats.size() == NBEAT) begin
            tests++; if (beats[0].cyc != t_last + 2) begin fails++; $display("FAIL ferr_latency got cycle %0d want %0d", beats[0].cyc, t_last + 2); end
            for (int k = 0; k < NBEAT; k++) begin
                tests++;
                if (beats[k].data !== exp_beat(k, 10) || beats[k].sof !== (k == 0) || beats[k].eof !== (k == 31)) begin
                    fails++;
                    $display("FAIL ferr_beat%0d got %h want %h", k, beats[k].data, exp_beat(k, 10));
                end
            end
        end
        $display("[TB] frame error: partial frame discarded, %0d beats received", beats.size());
    endtask

    task automatic test_reset_mid();
        int t_last;
        bit ok;
        int i;
        do_reset();
        send_frame(11, NBEAT, t_last);
        go_idle();
        for (i = 0; i < 100 && beats.size() < 16; i++) begin
            @(negedge clk); #1;
        end
        tests++; if (beats.size() != 16) begin fails++; $display("FAIL rmid_reach got %0d beats want 16", beats.size()); end
        else begin
            tests++; if (beats[15].data !== exp_beat(15, 11)) begin fails++; $display("FAIL rmid_beat15 got %h want %h", beats[15].data, exp_beat(15, 11)); end
        end
        rst = 1'b0;
        #1;
        tests++; if ({out_valid, out_sof, out_eof, overflow, frame_err} !== 5'b0) begin fails++; $display("FAIL rmid_ctrl got %b want 00000", {out_valid, out_sof, out_eof, overflow, frame_err}); end
        tests++; if ({binOut0, binOut1, binOut2, binOut3} !== '0) begin fails++; $display("FAIL rmid_bins got %h want 0", {binOut0, binOut1, binOut2, binOut3}); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        beats.delete();
        send_frame(12, NBEAT, t_last);
        go_idle();
        wait_beats(NBEAT, 100, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rmid_timeout got %0d beats want %0d", beats.size(), NBEAT); end
        repeat (5) @(posedge clk);
        tests++; if (beats.size() != NBEAT) begin fails++; $display("FAIL rmid_count got %0d want %0d", beats.size(), NBEAT); end
        if (beats.size() == NBEAT) begin
            for (int k = 0; k < NBEAT; k++) begin
                tests++;
                if (beats[k].data !== exp_beat(k, 12) || beats[k].sof !== (k == 0) || beats[k].eof !== (k == 31)) begin
                    fails++;
                    $display("FAIL rmid_beat%0d got %h want %h", k, beats[k].data, exp_beat(k, 12));
                end
            end
        end
        $display("[TB] reset mid-output: new frame delivered with %0d beats", beats.size());
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall_toggle();
        test_overflow();
        test_frame_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
